// File: rtl/reg_file_seq.sv
// reg_file_seq: four-phase sequencer executing one register-to-register instruction on a 4x4-bit register file
//   clk, rst_n         clock, asynchronous active-low reset
//   instr_valid/instr  instruction handshake input {op, rd, rs, imm}
//   instr_ready        high while idle and able to accept
//   out_a/out_b        register file read data for sel_a/sel_b
//   sel_a/sel_b/sel_w  register file read/write selects (latched rd, rs, rd)
//   write_en/data_in   register file write strobe and data
//   done               one-cycle retire pulse, coincident with write_en
//   carry/zero         flags of the last result
module reg_file_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [9:0] instr,
  output logic       instr_ready,
  input  logic [3:0] out_a,
  input  logic [3:0] out_b,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic [1:0] sel_w,
  output logic       write_en,
  output logic [3:0] data_in,
  output logic       done,
  output logic       carry,
  output logic       zero
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t     state_q;
  logic [9:0] instr_q;
  logic [3:0] opa_q, opb_q, res_q, res_d;
  logic       carry_q, carry_d, zero_q;
  logic [4:0] sum;
  logic [1:0] op;
  assign op = instr_q[9:8];
  // SUB reuses the adder as opA + ~opB + 1; its bit 4 is the inverted borrow
  always_comb begin
    sum     = op[0] ? {1'b0, opa_q} + {1'b0, ~opb_q} + 5'd1 : {1'b0, opa_q} + {1'b0, opb_q};
    res_d   = op[1] ? sum[3:0] : (op[0] ? opb_q : instr_q[3:0]);
    carry_d = op[1] ? (sum[4] ^ op[0]) : carry_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (instr_valid) begin
          instr_q <= instr;
          state_q <= READ;
        end
        READ: begin
          opa_q   <= out_a;
          opb_q   <= out_b;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          zero_q  <= res_d == 4'd0;
          state_q <= WRITE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Outputs decode only registered state, so reset removes write_en without waiting for an edge
  assign instr_ready = state_q == IDLE;
  assign write_en    = state_q == WRITE;
  assign done        = state_q == WRITE;
  assign sel_a       = instr_q[7:6];
  assign sel_w       = instr_q[7:6];
  assign sel_b       = instr_q[5:4];
  assign data_in     = res_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
endmodule
